// File: rtl/skid_pkg.sv
// rtl/skid_pkg.sv - shared mode constants and width helper for the skid buffer
package skid_pkg;

  localparam int SKID_REGISTERED = 0;
  localparam int SKID_BYPASS     = 1;

  // Occupancy must be able to represent DEPTH itself, hence depth + 1.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/skid_ring_mem.sv
// rtl/skid_ring_mem.sv - DEPTH x DATA_W ring storage with wrapping read/write pointers
module skid_ring_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
    end
  end

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/param_skid_buffer.sv
// rtl/param_skid_buffer.sv - multi-entry valid/ready skid buffer with optional bypass
module param_skid_buffer
  import skid_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  DEPTH  = 2,
  parameter int  BYPASS = SKID_REGISTERED,
  localparam int CNT_W  = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush_i,
  input  logic              i_valid_i,
  input  logic [DATA_W-1:0] i_data_i,
  output logic              i_ready_o,
  input  logic              e_ready_i,
  output logic              e_valid_o,
  output logic [DATA_W-1:0] e_data_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_next;
  logic              ready_q;
  logic              empty;
  logic              pass_mode;
  logic              push;
  logic              pop;
  logic              st_push;
  logic              st_pop;
  logic [DATA_W-1:0] head_data;

  assign empty     = (count_q == '0);
  assign pass_mode = (BYPASS == SKID_BYPASS) && empty;
  assign i_ready_o = ready_q & ~flush_i;
  assign push      = i_valid_i & i_ready_o;
  assign pop       = e_valid_o & e_ready_i;

  // A bypassed beat is only offered when it is also accepted on the input side,
  // so reset (ready_q = 0) and flush silence the output too.
  always_comb begin
    e_valid_o = 1'b0;
    e_data_o  = '0;
    if (!empty) begin
      e_valid_o = ~flush_i;
      e_data_o  = flush_i ? '0 : head_data;
    end else if (pass_mode) begin
      e_valid_o = i_valid_i & i_ready_o;
      e_data_o  = (i_valid_i & i_ready_o) ? i_data_i : '0;
    end
  end

  assign st_push = push & ~(pass_mode & e_ready_i);
  assign st_pop  = pop & ~empty;

  always_comb begin
    count_next = count_q;
    if (flush_i) count_next = '0;
    else         count_next = count_q + CNT_W'(st_push) - CNT_W'(st_pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      count_q <= count_next;
      ready_q <= (count_next < CNT_W'(DEPTH));
    end
  end

  skid_ring_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush_i),
    .wr_en   (st_push),
    .wr_data (i_data_i),
    .rd_en   (st_pop),
    .rd_data (head_data)
  );

  assign count_o = count_q;

endmodule

// File: tb/tb_param_skid_buffer.sv
// tb/tb_param_skid_buffer.sv - self-checking bench for param_skid_buffer
module tb_param_skid_buffer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  logic i_valid = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic e_ready = 1'b0;

  // Instances: 0 = DEPTH2 reg, 1 = DEPTH4 reg, 2 = DEPTH3 bypass, 3 = DEPTH3 reg
  logic [3:0]      i_ready;
  logic [3:0]      e_valid;
  logic [3:0][7:0] e_data;
  logic [1:0]      cnt_a;
  logic [2:0]      cnt_b;
  logic [1:0]      cnt_c;
  logic [1:0]      cnt_d;
  logic [2:0]      cnt [4];

  assign cnt[0] = {1'b0, cnt_a};
  assign cnt[1] = cnt_b;
  assign cnt[2] = {1'b0, cnt_c};
  assign cnt[3] = {1'b0, cnt_d};

  int checks = 0;
  int failures = 0;

  int         mdepth [4] = '{2, 4, 3, 3};
  bit         mbyp   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  bit         mready [4];
  logic [7:0] mq     [4][$];

  always #5 clk = ~clk;

  param_skid_buffer #(.DATA_W(8), .DEPTH(2), .BYPASS(0)) u_a (
    .clk(clk), .reset_n(reset_n), .flush_i(flush), .i_valid_i(i_valid), .i_data_i(i_data),
    .i_ready_o(i_ready[0]), .e_ready_i(e_ready), .e_valid_o(e_valid[0]), .e_data_o(e_data[0]),
    .count_o(cnt_a));
  param_skid_buffer #(.DATA_W(8), .DEPTH(4), .BYPASS(0)) u_b (
    .clk(clk), .reset_n(reset_n), .flush_i(flush), .i_valid_i(i_valid), .i_data_i(i_data),
    .i_ready_o(i_ready[1]), .e_ready_i(e_ready), .e_valid_o(e_valid[1]), .e_data_o(e_data[1]),
    .count_o(cnt_b));
  param_skid_buffer #(.DATA_W(8), .DEPTH(3), .BYPASS(1)) u_c (
    .clk(clk), .reset_n(reset_n), .flush_i(flush), .i_valid_i(i_valid), .i_data_i(i_data),
    .i_ready_o(i_ready[2]), .e_ready_i(e_ready), .e_valid_o(e_valid[2]), .e_data_o(e_data[2]),
    .count_o(cnt_c));
  param_skid_buffer #(.DATA_W(8), .DEPTH(3), .BYPASS(0)) u_d (
    .clk(clk), .reset_n(reset_n), .flush_i(flush), .i_valid_i(i_valid), .i_data_i(i_data),
    .i_ready_o(i_ready[3]), .e_ready_i(e_ready), .e_valid_o(e_valid[3]), .e_data_o(e_data[3]),
    .count_o(cnt_d));

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; flush = 1'b0; i_valid = 1'b0; e_ready = 1'b0; i_data = 8'h00;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; i_valid = 1'b1; i_data = 8'h11; e_ready = 1'b1;
    #1;
    checks++; if (i_ready[0] !== 1'b0) begin failures++; $display("FAIL reset_i_ready got=%0b exp=0", i_ready[0]); end
    checks++; if (e_valid[0] !== 1'b0) begin failures++; $display("FAIL reset_e_valid got=%0b exp=0", e_valid[0]); end
    checks++; if (cnt[0] !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt[0]); end
    checks++; if (e_valid[2] !== 1'b0) begin failures++; $display("FAIL reset_bypass_e_valid got=%0b exp=0", e_valid[2]); end
    tick();
    reset_n = 1'b1;
    #1;
    checks++; if (i_ready[0] !== 1'b0) begin failures++; $display("FAIL release_i_ready_before_edge got=%0b exp=0", i_ready[0]); end
    tick();
    checks++; if (i_ready[0] !== 1'b1) begin failures++; $display("FAIL release_i_ready_after_edge got=%0b exp=1", i_ready[0]); end
    checks++; if (e_valid[0] !== 1'b0) begin failures++; $display("FAIL release_e_valid_before_push got=%0b exp=0", e_valid[0]); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      i_data = 8'h11 + 8'(k);
      #1;
      checks++;
      if (e_valid[0] !== 1'b1 || e_data[0] !== 8'h11 + 8'(k - 1) || i_ready[0] !== 1'b1) begin
        failures++;
        $display("FAIL stream_beat%0d got v=%0b d=%02h r=%0b exp v=1 d=%02h r=1",
                 k, e_valid[0], e_data[0], i_ready[0], 8'h11 + 8'(k - 1));
      end
    end
  endtask

  task automatic test_fill_stall();
    do_reset();
    e_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1; i_data = 8'hA0 + 8'(k);
      #1;
      checks++; if (i_ready[1] !== 1'b1) begin failures++; $display("FAIL fill_ready%0d got=%0b exp=1", k, i_ready[1]); end
      tick();
    end
    i_valid = 1'b0;
    #1;
    checks++; if (cnt[1] !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", cnt[1]); end
    checks++; if (i_ready[1] !== 1'b0) begin failures++; $display("FAIL full_i_ready got=%0b exp=0", i_ready[1]); end
    e_ready = 1'b1;
    #1;
    checks++; if (i_ready[1] !== 1'b0) begin failures++; $display("FAIL full_pop_i_ready got=%0b exp=0", i_ready[1]); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (e_valid[1] !== 1'b1 || e_data[1] !== 8'hA0 + 8'(k)) begin
        failures++;
        $display("FAIL drain%0d got v=%0b d=%02h exp v=1 d=%02h", k, e_valid[1], e_data[1], 8'hA0 + 8'(k));
      end
      tick();
      if (k == 0) begin
        checks++; if (i_ready[1] !== 1'b1) begin failures++; $display("FAIL ready_after_pop got=%0b exp=1", i_ready[1]); end
      end
    end
    checks++; if (e_valid[1] !== 1'b0 || cnt[1] !== 3'd0) begin failures++; $display("FAIL drained got v=%0b c=%0d exp v=0 c=0", e_valid[1], cnt[1]); end
  endtask

  task automatic test_bypass();
    do_reset();
    e_ready = 1'b1; i_valid = 1'b1; i_data = 8'h5A;
    #1;
    checks++;
    if (e_valid[2] !== 1'b1 || e_data[2] !== 8'h5A || cnt[2] !== 3'd0 || i_ready[2] !== 1'b1) begin
      failures++;
      $display("FAIL bypass_pass got v=%0b d=%02h c=%0d r=%0b exp v=1 d=5a c=0 r=1", e_valid[2], e_data[2], cnt[2], i_ready[2]);
    end
    tick();
    e_ready = 1'b0; i_data = 8'h5B;
    #1;
    checks++; if (cnt[2] !== 3'd0) begin failures++; $display("FAIL bypass_count_stays got=%0d exp=0", cnt[2]); end
    tick();
    i_valid = 1'b0;
    #1;
    checks++;
    if (cnt[2] !== 3'd1 || e_valid[2] !== 1'b1 || e_data[2] !== 8'h5B) begin
      failures++;
      $display("FAIL bypass_hold got c=%0d v=%0b d=%02h exp c=1 v=1 d=5b", cnt[2], e_valid[2], e_data[2]);
    end
  endtask

  task automatic test_flush();
    do_reset();
    e_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_valid = 1'b1; i_data = 8'hC1 + 8'(k);
      tick();
    end
    flush = 1'b1; i_valid = 1'b1; i_data = 8'hC3;
    #1;
    checks++;
    if (e_valid[1] !== 1'b0 || i_ready[1] !== 1'b0 || e_data[1] !== 8'h00) begin
      failures++;
      $display("FAIL flush_cycle got v=%0b r=%0b d=%02h exp v=0 r=0 d=00", e_valid[1], i_ready[1], e_data[1]);
    end
    tick();
    flush = 1'b0; i_valid = 1'b0;
    #1;
    checks++;
    if (cnt[1] !== 3'd0 || i_ready[1] !== 1'b1 || e_valid[1] !== 1'b0) begin
      failures++;
      $display("FAIL flush_after got c=%0d r=%0b v=%0b exp c=0 r=1 v=0", cnt[1], i_ready[1], e_valid[1]);
    end
    checks++; if (i_ready[0] !== 1'b1 || cnt[0] !== 3'd0) begin failures++; $display("FAIL flush_full_depth2 got r=%0b c=%0d exp r=1 c=0", i_ready[0], cnt[0]); end
  endtask

  task automatic test_midstream_reset();
    do_reset();
    e_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1; i_data = 8'hD0 + 8'(k);
      tick();
    end
    i_valid = 1'b0;
    #1;
    checks++; if (cnt[1] !== 3'd3) begin failures++; $display("FAIL midreset_pre_count got=%0d exp=3", cnt[1]); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (e_valid[1] !== 1'b0 || e_data[1] !== 8'h00 || cnt[1] !== 3'd0 || i_ready[1] !== 1'b0) begin
      failures++;
      $display("FAIL midreset got v=%0b d=%02h c=%0d r=%0b exp all 0", e_valid[1], e_data[1], cnt[1], i_ready[1]);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_random_wrap();
    int   size;
    bit   ir, ev, popd;
    logic [7:0] ed;
    int   shown = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      mready[k] = 1'b1;
    end
    for (int c = 0; c < 400; c++) begin
      i_valid = ($urandom_range(3) != 0);
      e_ready = 1'($urandom_range(1));
      flush   = ($urandom_range(39) == 0);
      i_data  = 8'($urandom);
      #1;
      for (int k = 0; k < 4; k++) begin
        size = mq[k].size();
        ir   = mready[k] & ~flush;
        ev   = flush ? 1'b0 : (size > 0) ? 1'b1 : (mbyp[k] ? (i_valid & ir) : 1'b0);
        ed   = !ev ? 8'h00 : (size > 0) ? mq[k][0] : i_data;
        checks++;
        if (i_ready[k] !== ir || e_valid[k] !== ev || e_data[k] !== ed || cnt[k] !== 3'(size)) begin
          failures++;
          if (shown < 20) begin
            shown++;
            $display("FAIL random dut%0d cyc%0d got r=%0b v=%0b d=%02h c=%0d exp r=%0b v=%0b d=%02h c=%0d",
                     k, c, i_ready[k], e_valid[k], e_data[k], cnt[k], ir, ev, ed, size);
          end
        end
        checks++;
        if (int'(cnt[k]) > mdepth[k]) begin
          failures++;
          $display("FAIL random_count_bound dut%0d got=%0d max=%0d", k, cnt[k], mdepth[k]);
        end
        if (flush) begin
          mq[k].delete();
          mready[k] = 1'b1;
        end else begin
          popd = ev & e_ready;
          if (popd && size > 0) void'(mq[k].pop_front());
          if (i_valid && ir && !(popd && size == 0)) mq[k].push_back(i_data);
          mready[k] = (mq[k].size() < mdepth[k]);
        end
      end
      tick();
    end
    flush = 1'b0; i_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_stall();
    test_bypass();
    test_flush();
    test_midstream_reset();
    test_random_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
